ldm_stm_seq: RTL
================

# ldm_stm_seq

Block-transfer sequencer for LDM/STM. Turns one multiple-register instruction into a series of single-word memory transfers, driving register-file read addresses (STM) or write ports (LDM) plus the base-register writeback. Sits beside the memory stage and acts as the initiator on the register-file port interface. The pipeline is stalled while `busy` is high.

## Interface
- No parameters. Word size is 32 bits; the register index is 4 bits.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a transfer; sampled only in IDLE.
- `is_load` in 1: 1 = LDM, 0 = STM.
- `reglist` in 16: register list; bit i selects Ri.
- `rn` in 4: base register index.
- `base` in 32: base register value.
- `up` in 1: U bit; 1 = increment.
- `pre` in 1: P bit; 1 = before.
- `wback` in 1: W bit.
- `busy` out 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle completion pulse.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: 1 = store.
- `mem_addr` out 32: word address.
- `mem_wdata` out 32: store data, equal to `rf_rd`.
- `mem_ready` in 1: memory accepts or completes the request this cycle.
- `mem_rdata` in 32: load data, valid when `mem_ready` is high.
- `rf_ra` out 4: register-file read address (STM).
- `rf_rd` in 32: register-file read data.
- `rf_we` out 1, `rf_wa` out 4, `rf_wd` out 32: load write port.
- `rf_we_b` out 1, `rf_wa_b` out 4, `rf_wd_b` out 32: base writeback port.
- `pc_we` out 1, `pc_wd` out 32: load into R15, which is held outside the register file.

## Operation
- **FSM states:** IDLE, CALC, XFER, WB, DONE.
- **IDLE:** on `start`, latch all inputs and go to CALC. `start` is ignored in every other state.
- **CALC:** compute n = popcount(reglist), a 5-bit value (0..16).
  - Start address for IA (U=1, P=0): base.
  - IB (U=1, P=1): base+4.
  - DA (U=0, P=0): base−4n+4.
  - DB (U=0, P=1): base−4n.
  - Writeback value: base+4n if U, else base−4n.
  - All arithmetic is 32-bit modulo 2^32; wrap-around is silent.
  - Next state: XFER if n>0, else WB.
- **XFER:**
  - idx = lowest set bit of the remaining mask. `mem_req`=1, `mem_addr`=current address, `mem_we`=!is_load, `rf_ra`=idx.
  - On a cycle with `mem_req`&&`mem_ready`:
    - LDM with idx≠15: `rf_we`=1, `rf_wa`=idx, `rf_wd`=`mem_rdata`.
    - LDM with idx=15: `pc_we`=1, `pc_wd`=`mem_rdata`, `rf_we`=0.
    - Then clear bit idx from the mask and add 4 to the address.
  - When the mask becomes empty, go to WB.
  - Registers are always transferred in ascending index order at ascending addresses, for all four modes.
- **WB:**
  - If `wback`, drive `rf_we_b`=1, `rf_wa_b`=rn, `rf_wd_b`=writeback value.
  - Exceptions: writeback is suppressed when n=0, and when is_load with reglist[rn]=1 (the loaded value wins).
  - Rn = 15 with W: writeback is suppressed.
  - Next state is DONE.
- **DONE:** `done`=1, `busy`=1, then IDLE.
- **STM with Rn in the list:** the stored value is the original base, because WB occurs after all stores.

## Timing
- **Reset:** asynchronous assertion forces IDLE and clears the mask and address. All outputs are 0 while reset is held and in IDLE.
- **Reset mid-operation:** the transfer is abandoned with no further `mem_req` or writes. A partially completed LDM is not rolled back.
- **Latency:** with `start` sampled at edge T and `mem_ready` constantly 1, edges are T+1 CALC, T+2..T+1+n XFER, T+2+n WB, T+3+n DONE. `done` is high in the cycle after edge T+3+n. Each `mem_ready`=0 cycle adds one cycle.
- **Stalled request:** while `mem_ready`=0, `mem_req`, `mem_addr`, `mem_we` and `rf_ra` hold stable, and no register write occurs.
- **Write ports:** `rf_we`, `rf_we_b` and `pc_we` are combinational decodes of state and handshake, valid in the handshake or WB cycle. `rf_we` and `rf_we_b` are never high in the same cycle.
- **Back-to-back:** a `start` during the DONE cycle is ignored. The next `start` is accepted in IDLE, one cycle after DONE.

## Structure
- **Shared package (`arm_pkg`):**
  - State enum `seq_state_t`.
  - Constants `WORD_BYTES`=4 and `PC_IDX`=4'd15.
  - Helper `popcount16`.
- **Sub-module `lsb_pick`:** 16-bit lowest-set-bit priority encoder. Outputs a 4-bit index and a `none` flag.

## Test plan
- **LDM IA, no wait states:** reglist=0x000E, base=0x100, W=1, `mem_ready`=1. R1/R2/R3 are written from 0x100/0x104/0x108. `rf_wd_b`=0x10C in WB. `done` in the cycle after edge T+6.
- **STM DB with stalls:** reglist=0x8011, base=0x200, `mem_ready` low for 2 cycles on the second beat. Stores R0 at 0x1F4, R4 at 0x1F8, R15 at 0x1FC, with address held stable during the stall. No writeback when W=0.
- **Empty list:** reglist=0, W=1. No `mem_req`, no writeback, `done` in the cycle after edge T+3.
- **Base in list and R15:** LDM IB, rn=2, reglist=0x8004, W=1. R2 gets loaded data, writeback is suppressed, `pc_we` on the R15 beat, no `rf_we` for index 15.
- **Wrap-around:** STM IA, base=0xFFFFFFFC, reglist=0x0003. Addresses 0xFFFFFFFC then 0x00000000. Writeback value 0x00000004.
- **Reset mid-XFER:** drop `reset` during beat 2 of 4. All outputs go to 0 immediately. After release, the FSM is in IDLE and a new `start` runs normally.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
// Word size is 32 bits, register index is 4 bits.
package arm_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_XFER = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } seq_state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [3:0]  PC_IDX     = 4'd15;

  function automatic logic [4:0] popcount16(
    input logic [15:0] v
  );
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++)
      c = c + {4'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_seq_if.sv
// Memory and register-file port bundle driven by the sequencer.
// The sequencer is the master (initiator) on both ports.
interface ldm_stm_seq_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [3:0]  rf_ra;
  logic [31:0] rf_rd;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        rf_we_b;
  logic [3:0]  rf_wa_b;
  logic [31:0] rf_wd_b;
  logic        pc_we;
  logic [31:0] pc_wd;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    output rf_ra, rf_we, rf_wa, rf_wd,
    output rf_we_b, rf_wa_b, rf_wd_b,
    output pc_we, pc_wd,
    input  mem_ready, mem_rdata, rf_rd
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  rf_ra, rf_we, rf_wa, rf_wd,
    input  rf_we_b, rf_wa_b, rf_wd_b,
    input  pc_we, pc_wd,
    output mem_ready, mem_rdata, rf_rd
  );

endinterface

// File: rtl/ldm_stm_seq_lsb_pick.sv
// 16-bit lowest-set-bit priority encoder.
// none is high when the mask is empty.
module lsb_pick (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        none
);

  always_comb begin
    idx  = '0;
    none = (mask == '0);
    for (int i = 15; i >= 0; i--)
      if (mask[i]) idx = 4'(i);
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: one multi-register op becomes a run of
// single-word transfers plus an optional base writeback.
module ldm_stm_seq
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic [15:0] reglist,
  input  logic [3:0]  rn,
  input  logic [31:0] base,
  input  logic        up,
  input  logic        pre,
  input  logic        wback,
  output logic        busy,
  output logic        done,
  ldm_stm_seq_if.master bus
);

  seq_state_t  state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wbv_q, wbv_d;
  logic [3:0]  rn_q, rn_d;
  logic        load_q, load_d;
  logic        up_q, up_d;
  logic        pre_q, pre_d;
  logic        wben_q, wben_d;

  logic [3:0]  idx;
  logic        none;
  logic [4:0]  n;
  logic [31:0] span;
  logic [15:0] mask_clr;

  lsb_pick u_pick (
    .mask (mask_q),
    .idx  (idx),
    .none (none)
  );

  assign n        = popcount16(mask_q);
  assign span     = {25'b0, n, 2'b00};
  assign mask_clr = mask_q & ~(16'b1 << idx);

  assign bus.mem_wdata = bus.mem_req ? bus.rf_rd : '0;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wbv_d   = wbv_q;
    rn_d    = rn_q;
    load_d  = load_q;
    up_d    = up_q;
    pre_d   = pre_q;
    wben_d  = wben_q;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.mem_addr = '0;
    bus.rf_ra   = '0;
    bus.rf_we   = 1'b0;
    bus.rf_wa   = '0;
    bus.rf_wd   = '0;
    bus.rf_we_b = 1'b0;
    bus.rf_wa_b = '0;
    bus.rf_wd_b = '0;
    bus.pc_we   = 1'b0;
    bus.pc_wd   = '0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CALC;
        mask_d  = reglist;
        addr_d  = base;
        rn_d    = rn;
        load_d  = is_load;
        up_d    = up;
        pre_d   = pre;
        // a loaded base or an R15 base never gets written back
        wben_d  = wback && !(is_load && reglist[rn])
                  && (rn != PC_IDX);
      end
      S_CALC: begin
        wbv_d  = up_q ? addr_q + span : addr_q - span;
        if (up_q)
          addr_d = pre_q ? addr_q + WORD_BYTES : addr_q;
        else
          addr_d = pre_q ? addr_q - span
                         : addr_q - span + WORD_BYTES;
        wben_d  = wben_q && (n != 5'd0);
        state_d = (n != 5'd0) ? S_XFER : S_WB;
      end
      S_XFER: if (none) begin
        state_d = S_WB;
      end else begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = !load_q;
        bus.mem_addr = addr_q;
        bus.rf_ra    = idx;
        if (bus.mem_ready) begin
          if (load_q && idx == PC_IDX) begin
            bus.pc_we = 1'b1;
            bus.pc_wd = bus.mem_rdata;
          end else if (load_q) begin
            bus.rf_we = 1'b1;
            bus.rf_wa = idx;
            bus.rf_wd = bus.mem_rdata;
          end
          mask_d = mask_clr;
          addr_d = addr_q + WORD_BYTES;
          if (mask_clr == '0) state_d = S_WB;
        end
      end
      S_WB: begin
        bus.rf_we_b = wben_q;
        bus.rf_wa_b = wben_q ? rn_q : '0;
        bus.rf_wd_b = wben_q ? wbv_q : '0;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      wbv_q   <= '0;
      rn_q    <= '0;
      load_q  <= 1'b0;
      up_q    <= 1'b0;
      pre_q   <= 1'b0;
      wben_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wbv_q   <= wbv_d;
      rn_q    <= rn_d;
      load_q  <= load_d;
      up_q    <= up_d;
      pre_q   <= pre_d;
      wben_q  <= wben_d;
    end
  end

endmodule
